// File: rtl/max7219_cmd_loader.sv
// max7219_cmd_loader: streams command words into the max7219_cmd_decod RAM and arms playback.
module max7219_cmd_loader #(
   parameter int G_RAM_ADDR_WIDTH = 8,
   parameter int G_RAM_DATA_WIDTH = 16,
   parameter int G_TIMEOUT_CNT    = 100000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_en,
   input  logic                        i_cmd_valid,
   input  logic [G_RAM_DATA_WIDTH-1:0] i_cmd_data,
   input  logic                        i_cmd_last,
   input  logic                        i_loop_req,
   input  logic [G_RAM_ADDR_WIDTH-1:0] i_base_addr,
   output logic                        o_cmd_ready,
   output logic                        o_me,
   output logic                        o_we,
   output logic [G_RAM_ADDR_WIDTH-1:0] o_addr,
   output logic [G_RAM_DATA_WIDTH-1:0] o_wdata,
   output logic [G_RAM_ADDR_WIDTH-1:0] o_start_ptr,
   output logic [G_RAM_ADDR_WIDTH-1:0] o_last_ptr,
   output logic                        o_ptr_val,
   output logic                        o_loop,
   input  logic                        i_ptr_equality,
   input  logic                        i_discard,
   output logic                        o_busy,
   output logic                        o_frame_done,
   output logic [2:0]                  o_err
);
   localparam int AW = G_RAM_ADDR_WIDTH;
   localparam int DW = G_RAM_DATA_WIDTH;
   localparam int TW = (G_TIMEOUT_CNT > 1) ? $clog2(G_TIMEOUT_CNT) : 1;
   localparam logic [TW-1:0] TMO_MAX = TW'(G_TIMEOUT_CNT - 1);
   typedef enum logic [1:0] {IDLE, WRITE, ARM, WAIT_PLAY} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d, last_ptr_q, last_ptr_d;
   logic [AW-1:0] addr_q, addr_d, pstart_q, pstart_d, plast_q, plast_d;
   logic [AW:0] word_cnt_q, word_cnt_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0] err_q, err_d;
   logic loop_q, loop_d, ploop_q, ploop_d, me_q, me_d, ptr_val_q, ptr_val_d, done_q, done_d;
   logic accept, fin, chk;
   logic [AW-1:0] waddr;
   logic [AW:0] cnt_n;
   assign o_cmd_ready = i_en & (state_q == IDLE || state_q == WRITE);
   assign accept = o_cmd_ready & i_cmd_valid;
   assign waddr = (state_q == IDLE) ? i_base_addr : wr_ptr_q + AW'(1);
   assign cnt_n = (state_q == IDLE) ? (AW+1)'(1) : word_cnt_q + (AW+1)'(1);
   // word count only reaches bit AW when the frame hits RAM capacity
   assign fin = accept & (i_cmd_last | cnt_n[AW]);
   // the strobe cycle itself is not a response window for the decoder
   assign chk = ~ptr_val_q;
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = accept ? waddr : wr_ptr_q;
      word_cnt_d  = accept ? cnt_n : word_cnt_q;
      start_ptr_d = (accept && state_q == IDLE) ? i_base_addr : start_ptr_q;
      last_ptr_d  = fin ? waddr : last_ptr_q;
      loop_d      = fin ? (i_cmd_last & i_loop_req) : loop_q;
      me_d        = accept;
      addr_d      = accept ? waddr : addr_q;
      wdata_d     = accept ? i_cmd_data : wdata_q;
      ptr_val_d   = 1'b0;
      pstart_d    = pstart_q;
      plast_d     = plast_q;
      ploop_d     = ploop_q;
      done_d      = 1'b0;
      err_d       = {fin & ~i_cmd_last, 2'b00};
      tmo_d       = '0;
      if (accept) state_d = fin ? ARM : WRITE;
      if (i_en && state_q == ARM) begin
         ptr_val_d = 1'b1;
         pstart_d  = start_ptr_q;
         plast_d   = last_ptr_q;
         ploop_d   = loop_q;
         state_d   = WAIT_PLAY;
      end
      if (i_en && state_q == WAIT_PLAY) begin
         tmo_d = tmo_q + TW'(1);
         if (chk && i_discard) begin
            err_d[0] = 1'b1;
            state_d  = IDLE;
         end else if (chk && i_ptr_equality) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end else if (tmo_q == TMO_MAX) begin
            err_d[1] = 1'b1;
            state_d  = IDLE;
         end
      end
      if (!i_en) state_d = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         word_cnt_q  <= '0;
         start_ptr_q <= '0;
         last_ptr_q  <= '0;
         loop_q      <= 1'b0;
         me_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ptr_val_q   <= 1'b0;
         pstart_q    <= '0;
         plast_q     <= '0;
         ploop_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         word_cnt_q  <= word_cnt_d;
         start_ptr_q <= start_ptr_d;
         last_ptr_q  <= last_ptr_d;
         loop_q      <= loop_d;
         me_q        <= me_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ptr_val_q   <= ptr_val_d;
         pstart_q    <= pstart_d;
         plast_q     <= plast_d;
         ploop_q     <= ploop_d;
         done_q      <= done_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end
   assign o_me         = me_q;
   assign o_we         = me_q;
   assign o_addr       = addr_q;
   assign o_wdata      = wdata_q;
   assign o_start_ptr  = pstart_q;
   assign o_last_ptr   = plast_q;
   assign o_ptr_val    = ptr_val_q;
   assign o_loop       = ploop_q;
   assign o_busy       = (state_q != IDLE);
   assign o_frame_done = done_q;
   assign o_err        = err_q;
endmodule
